// File: rtl/if_fetch_ctrl_pkg.sv
// Shared constants for the instruction-fetch sequencer.
package if_fetch_ctrl_pkg;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [63:0] PC_STEP          = 64'd4;

    // Sequential fetch address; wraps modulo 2^64.
    function automatic logic [63:0] seq_pc(input logic [63:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request/response bus (one outstanding request).
interface if_fetch_ctrl_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );

endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues one request at a
// time, discards stale responses after a redirect and presents the fetched
// instruction to the IF/ID register.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    if_fetch_ctrl_if.master        imem,
    input  logic                   id_stall,
    input  logic                   redirect_valid,
    input  logic [63:0]            redirect_pc,
    input  logic                   redirect_trap,
    output logic [63:0]            if_pc,
    output logic [31:0]            if_instr,
    output logic                   if_valid,
    output logic                   if_time_set
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DROP,
        S_HOLD
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [63:0] fetch_pc;
    logic        trap_pend;
    logic        redir_take;
    logic        capture;
    logic        consume;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a redirect always wins over consumption or capture.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ: begin
                if (imem.imem_req_ready) begin
                    state_nxt = redirect_valid ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.imem_resp_valid) begin
                    state_nxt = redirect_valid ? S_REQ : S_HOLD;
                end else if (redirect_valid) begin
                    state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (imem.imem_resp_valid) begin
                    state_nxt = S_REQ;
                end
            end
            S_HOLD: begin
                if (redirect_valid || !id_stall) begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request outputs and datapath strobes decoded from the current state.
    always_comb begin
        imem.imem_req_valid = (state == S_REQ);
        imem.imem_req_addr  = fetch_pc;
        redir_take          = redirect_valid && (state != S_IDLE);
        capture             = (state == S_WAIT) && imem.imem_resp_valid && !redirect_valid;
        consume             = (state == S_HOLD) && !redirect_valid && !id_stall;
    end

    // Fetch PC, pending trap flag and the registered IF/ID outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            trap_pend   <= 1'b0;
            if_pc       <= RESET_PC;
            if_instr    <= '0;
            if_valid    <= 1'b0;
            if_time_set <= 1'b0;
        end else begin
            if (redir_take) begin
                fetch_pc <= redirect_pc;
            end else if (consume) begin
                fetch_pc <= seq_pc(fetch_pc);
            end

            if (redir_take) begin
                trap_pend <= redirect_trap;
            end else if (capture) begin
                trap_pend <= 1'b0;
            end

            if_valid <= (state_nxt == S_HOLD);
            if (capture) begin
                if_pc       <= fetch_pc;
                if_instr    <= imem.imem_resp_data;
                if_time_set <= trap_pend;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed vector table, hand-written
// redirect/reset sequences and a randomized run against a transaction model.
module tb_if_fetch_ctrl;
    import if_fetch_ctrl_pkg::*;

    localparam logic [63:0] RPC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        redirect_trap = 1'b0;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        if_time_set;

    int unsigned total = 0;
    int unsigned bad = 0;

    if_fetch_ctrl_if bus ();

    if_fetch_ctrl #(.RESET_PC(RPC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (bus),
        .id_stall       (id_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_trap  (redirect_trap),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_valid       (if_valid),
        .if_time_set    (if_time_set)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ready;
        logic        resp;
        logic [31:0] data;
        logic        stall;
        logic        redir;
        logic [63:0] rpc;
        logic        trap;
        logic        rv;
        logic [63:0] addr;
        logic        v;
        logic [63:0] pc;
        logic [31:0] instr;
        logic        ts;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic rsp, input logic [31:0] d,
                         input logic st, input logic rdv, input logic [63:0] rpc,
                         input logic tr);
        bus.imem_req_ready  = rdy;
        bus.imem_resp_valid = rsp;
        bus.imem_resp_data  = d;
        id_stall            = st;
        redirect_valid      = rdv;
        redirect_pc         = rpc;
        redirect_trap       = tr;
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_outs(input string tag, input logic rv, input logic [63:0] addr,
                              input logic v, input logic [63:0] pc,
                              input logic [31:0] instr, input logic ts);
        chk({tag, ".req_valid"}, 64'(bus.imem_req_valid), 64'(rv));
        chk({tag, ".req_addr"},  bus.imem_req_addr,       addr);
        chk({tag, ".if_valid"},  64'(if_valid),           64'(v));
        chk({tag, ".if_pc"},     if_pc,                   pc);
        chk({tag, ".if_instr"},  64'(if_instr),           64'(instr));
        chk({tag, ".time_set"},  64'(if_time_set),        64'(ts));
    endtask

    // Holds reset for two cycles, checks reset values, releases at a negedge
    // so the following cycle is the IDLE cycle.
    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        repeat (2) @(negedge clk);
        check_outs("reset", 1'b0, RPC, 1'b0, RPC, 32'h0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic add(input logic rdy, input logic rsp, input logic [31:0] d,
                       input logic st, input logic rdv, input logic [63:0] rpc,
                       input logic tr, input logic rv, input logic [63:0] addr,
                       input logic v, input logic [63:0] pc,
                       input logic [31:0] instr, input logic ts);
        vec_t e;
        e.ready = rdy; e.resp = rsp; e.data = d; e.stall = st;
        e.redir = rdv; e.rpc = rpc; e.trap = tr;
        e.rv = rv; e.addr = addr; e.v = v; e.pc = pc; e.instr = instr; e.ts = ts;
        tbl.push_back(e);
    endtask

    // Random-phase model state.
    logic [63:0] m_pc;
    logic [63:0] m_oaddr;
    logic [63:0] r_rpc;
    logic [31:0] r_data;
    logic        m_idle, m_outst, m_stale, m_v, m_trap, m_ts, m_rv;
    logic        r_rdy, r_st, r_rdv, r_tr, r_resp, fresh, nv;
    int unsigned m_cnt;

    initial begin
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);

        // ---------------- table-driven vectors ----------------
        //   rdy rsp data           st   rdv  rpc              tr  | rv addr         v  pc            instr          ts
        add(1, 0, 32'h0,          0, 0, 64'h0,          0,   0, RPC,          0, RPC,          32'h0,         0);
        add(1, 0, 32'h0,          0, 0, 64'h0,          0,   1, RPC,          0, RPC,          32'h0,         0);
        add(0, 1, NOP_INSTR,      0, 0, 64'h0,          0,   0, RPC,          0, RPC,          32'h0,         0);
        add(0, 0, 32'h0,          0, 0, 64'h0,          0,   0, RPC,          1, RPC,          NOP_INSTR,     0);
        add(1, 0, 32'h0,          0, 0, 64'h0,          0,   1, 64'h8000_0004, 0, RPC,          NOP_INSTR,     0);
        add(0, 1, 32'h0000_0093,  0, 0, 64'h0,          0,   0, 64'h8000_0004, 0, RPC,          NOP_INSTR,     0);
        for (int i = 0; i < 5; i++)
            add(1, 0, 32'h0,      1, 0, 64'h0,          0,   0, 64'h8000_0004, 1, 64'h8000_0004, 32'h0000_0093, 0);
        add(1, 0, 32'h0,          0, 0, 64'h0,          0,   0, 64'h8000_0004, 1, 64'h8000_0004, 32'h0000_0093, 0);
        add(1, 0, 32'h0,          0, 0, 64'h0,          0,   1, 64'h8000_0008, 0, 64'h8000_0004, 32'h0000_0093, 0);
        add(0, 1, 32'h0010_0113,  0, 0, 64'h0,          0,   0, 64'h8000_0008, 0, 64'h8000_0004, 32'h0000_0093, 0);
        add(0, 0, 32'h0,          0, 1, 64'h8000_0200,  1,   0, 64'h8000_0008, 1, 64'h8000_0008, 32'h0010_0113, 0);
        add(1, 0, 32'h0,          0, 0, 64'h0,          0,   1, 64'h8000_0200, 0, 64'h8000_0008, 32'h0010_0113, 0);
        add(0, 1, 32'h0000_0213,  0, 0, 64'h0,          0,   0, 64'h8000_0200, 0, 64'h8000_0008, 32'h0010_0113, 0);
        add(0, 0, 32'h0,          0, 0, 64'h0,          0,   0, 64'h8000_0200, 1, 64'h8000_0200, 32'h0000_0213, 1);
        add(1, 0, 32'h0,          0, 0, 64'h0,          0,   1, 64'h8000_0204, 0, 64'h8000_0200, 32'h0000_0213, 1);
        add(0, 1, 32'h0000_0313,  0, 0, 64'h0,          0,   0, 64'h8000_0204, 0, 64'h8000_0200, 32'h0000_0213, 1);
        add(0, 0, 32'h0,          0, 0, 64'h0,          0,   0, 64'h8000_0204, 1, 64'h8000_0204, 32'h0000_0313, 0);
        add(0, 0, 32'h0,          0, 0, 64'h0,          0,   1, 64'h8000_0208, 0, 64'h8000_0204, 32'h0000_0313, 0);
        add(0, 0, 32'h0,          0, 0, 64'h0,          0,   1, 64'h8000_0208, 0, 64'h8000_0204, 32'h0000_0313, 0);

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].ready, tbl[i].resp, tbl[i].data, tbl[i].stall,
                  tbl[i].redir, tbl[i].rpc, tbl[i].trap);
            check_outs($sformatf("vec%0d", i), tbl[i].rv, tbl[i].addr, tbl[i].v,
                       tbl[i].pc, tbl[i].instr, tbl[i].ts);
            tick();
        end

        // ---------------- redirect while WAIT, response two cycles later ----------------
        do_reset();
        tick();                                                   // IDLE -> REQ
        chk("seqA.req", 64'(bus.imem_req_valid), 64'd1);
        drive(1, 0, '0, 0, 0, '0, 0);
        tick();                                                   // accepted -> WAIT
        drive(0, 0, '0, 0, 1, 64'h8000_0100, 0);
        chk("seqA.wait_noreq", 64'(bus.imem_req_valid), 64'd0);
        tick();                                                   // -> DROP
        drive(0, 0, '0, 0, 0, '0, 0);
        chk("seqA.drop_noreq", 64'(bus.imem_req_valid), 64'd0);
        chk("seqA.drop_addr", bus.imem_req_addr, 64'h8000_0100);
        tick();
        drive(0, 1, 32'hDEAD_BEEF, 0, 0, '0, 0);                  // stale response
        chk("seqA.drop_novalid", 64'(if_valid), 64'd0);
        tick();
        drive(1, 0, '0, 0, 0, '0, 0);
        check_outs("seqA.after", 1'b1, 64'h8000_0100, 1'b0, RPC, 32'h0, 1'b0);
        tick();
        drive(0, 1, 32'h0000_0513, 1, 0, '0, 0);
        tick();
        check_outs("seqA.hold", 1'b0, 64'h8000_0100, 1'b1, 64'h8000_0100, 32'h0000_0513, 1'b0);

        // ---------------- mid-operation reset, then redirect with ready ----------------
        #2 rst_n = 1'b0;
        #1 check_outs("midrst", 1'b0, RPC, 1'b0, RPC, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, 32'h0BAD_0BAD, 0, 0, '0, 0);                  // stray response in IDLE
        tick();
        check_outs("seqB.req", 1'b1, RPC, 1'b0, RPC, 32'h0, 1'b0);
        drive(1, 0, '0, 0, 1, 64'h8000_0300, 0);                  // redirect with ready
        tick();
        check_outs("seqB.drop", 1'b0, 64'h8000_0300, 1'b0, RPC, 32'h0, 1'b0);
        drive(0, 1, 32'h0BAD_BAD0, 0, 0, '0, 0);
        tick();
        check_outs("seqB.req2", 1'b1, 64'h8000_0300, 1'b0, RPC, 32'h0, 1'b0);
        drive(1, 0, '0, 0, 0, '0, 0);
        tick();
        drive(0, 1, 32'h0000_0613, 1, 0, '0, 0);
        tick();
        check_outs("seqB.hold", 1'b0, 64'h8000_0300, 1'b1, 64'h8000_0300, 32'h0000_0613, 1'b0);

        // ---------------- randomized run against a transaction model ----------------
        do_reset();
        m_pc = RPC; m_idle = 1'b1; m_outst = 1'b0; m_stale = 1'b0; m_cnt = 0;
        m_oaddr = '0; m_v = 1'b0; m_trap = 1'b0; m_ts = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            // Outside reset the DUT requests exactly when nothing is outstanding
            // and nothing is being presented.
            m_rv = !m_idle && !m_outst && !m_v;
            chk("rnd.req_valid", 64'(bus.imem_req_valid), 64'(m_rv));
            if (m_rv) chk("rnd.req_addr", bus.imem_req_addr, m_pc);
            chk("rnd.if_valid", 64'(if_valid), 64'(m_v));
            if (m_v) begin
                chk("rnd.if_pc", if_pc, m_pc);
                chk("rnd.if_instr", 64'(if_instr), 64'(mem_word(m_pc)));
                chk("rnd.time_set", 64'(if_time_set), 64'(m_ts));
            end

            r_rdy  = 1'($urandom_range(0, 1));
            r_st   = ($urandom_range(0, 2) == 0);
            r_rdv  = !m_idle && ($urandom_range(0, 7) == 0);
            r_tr   = 1'($urandom_range(0, 1));
            r_rpc  = ($urandom_range(0, 9) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC
                                                 : {32'($urandom), 32'($urandom)} & ~64'h3;
            r_resp = m_outst && (m_cnt == 0);
            r_data = r_resp ? mem_word(m_oaddr) : 32'($urandom);
            drive(r_rdy, r_resp, r_data, r_st, r_rdv, r_rpc, r_tr);

            fresh = r_resp && !m_stale && !r_rdv;
            nv    = fresh || (m_v && r_st && !r_rdv);
            if (fresh) begin
                m_ts   = m_trap;
                m_trap = 1'b0;
            end
            if (m_v && !r_rdv && !r_st) m_pc = m_pc + 64'd4;
            if (r_resp) begin
                m_outst = 1'b0;
            end else if (m_outst) begin
                m_cnt--;
                if (r_rdv) m_stale = 1'b1;
            end
            if (m_rv && r_rdy) begin
                m_outst = 1'b1;
                m_stale = r_rdv;
                m_cnt   = $urandom_range(0, 2);
                m_oaddr = m_pc;
            end
            if (r_rdv) begin
                m_pc   = r_rpc;
                m_trap = r_tr;
            end
            m_v    = nv;
            m_idle = 1'b0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
